// File: rtl/k_vtgen_p_if.sv
// -----------------------------------------------------------------------------
// k_vtgen_p_if -- CPU register bus of the k_vtgen_p video timing generator.
//
// Signals:
//   PIN_CCS     chip select, active low            (master -> slave)
//   PIN_RW      1 = read, 0 = write                (master -> slave)
//   PIN_AB      5-bit register address             (master -> slave)
//   PIN_DB_IN   write data byte                    (master -> slave)
//   PIN_DB_OUT  read data byte, combinational      (slave  -> master)
//
// Modports: master = CPU side, slave = timing generator side.
// -----------------------------------------------------------------------------
interface k_vtgen_p_if;
    logic       PIN_CCS;
    logic       PIN_RW;
    logic [4:0] PIN_AB;
    logic [7:0] PIN_DB_IN;
    logic [7:0] PIN_DB_OUT;

    modport master (output PIN_CCS, PIN_RW, PIN_AB, PIN_DB_IN, input  PIN_DB_OUT);
    modport slave  (input  PIN_CCS, PIN_RW, PIN_AB, PIN_DB_IN, output PIN_DB_OUT);
endinterface

// File: rtl/k_vtgen_p.sv
// -----------------------------------------------------------------------------
// k_vtgen_p -- programmable CRTC: pixel-clock enable, H/V counters, windowed
// sync/blank outputs, optional interlace and NIRQ raster-line interrupts.
//
// Parameters: HW (H counter width), VW (V counter width), NIRQ (IRQ channels).
//
// Ports:
//   PIN_CLK, PIN_RESET     clock, synchronous active-high reset
//   cpu                    register bus (k_vtgen_p_if.slave)
//   PIN_PCE                pixel clock enable, one PIN_CLK wide
//   PIN_HCNT, PIN_VCNT     the H/V counters
//   PIN_NHSY, PIN_NVSY     H/V sync, active low
//   PIN_NHBK, PIN_NVBK     H/V blank, active low
//   PIN_NCBK, PIN_NCSY     composite blank / sync, active low
//   PIN_FIELD              current interlace field
//   PIN_INT                raster IRQs, active low
//
// Timing: counters advance on the clock where the divider matches DIV. Every
// sync/blank/IRQ pin is registered from the current counter state, so it
// shows the value belonging to the counters of the previous clock.
// -----------------------------------------------------------------------------
module k_vtgen_p #(
    parameter int HW   = 10,
    parameter int VW   = 9,
    parameter int NIRQ = 2
) (
    input  logic             PIN_CLK,
    input  logic             PIN_RESET,
    k_vtgen_p_if.slave       cpu,
    output logic             PIN_PCE,
    output logic [HW-1:0]    PIN_HCNT,
    output logic [VW-1:0]    PIN_VCNT,
    output logic             PIN_NHSY,
    output logic             PIN_NVSY,
    output logic             PIN_NHBK,
    output logic             PIN_NVBK,
    output logic             PIN_NCBK,
    output logic             PIN_NCSY,
    output logic             PIN_FIELD,
    output logic [NIRQ-1:0]  PIN_INT
);

    typedef logic [HW-1:0] h_t;
    typedef logic [VW-1:0] v_t;

    localparam h_t H_MAX = '1;
    localparam v_t V_MAX = '1;

    // Replace the lo or hi byte of a register; bits above its width drop out.
    function automatic h_t put_h(input h_t old, input logic hi, input logic [7:0] d);
        logic [15:0] w;
        w = 16'(old);
        if (hi) w[15:8] = d;
        else    w[7:0]  = d;
        return w[HW-1:0];
    endfunction

    function automatic v_t put_v(input v_t old, input logic hi, input logic [7:0] d);
        logic [15:0] w;
        w = 16'(old);
        if (hi) w[15:8] = d;
        else    w[7:0]  = d;
        return w[VW-1:0];
    endfunction

    // Window test; S > E wraps around the end of the line/frame, S == E is never active.
    function automatic logic win(input logic [15:0] c, input logic [15:0] s, input logic [15:0] e);
        if (s < e)      return (c >= s) && (c < e);
        else if (s > e) return (c >= s) || (c < e);
        else            return 1'b0;
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    // Programmed registers
    h_t            htot, hbs, hbe, hss, hse;
    v_t            vtot, vbs, vbe, vss, vse;
    logic          en, ilace;
    logic [1:0]    div;
    logic [NIRQ-1:0] irq_mask, irq_stat;
    v_t            line_r [NIRQ];
    v_t            sh_v;
    h_t            sh_h;

    // Timing state
    h_t            hcnt;
    v_t            vcnt;
    logic          field;
    logic [1:0]    div_cnt;
    logic          vsync_st;

    // Bus decode
    logic          wr_en, rd_en;
    logic [4:0]    ab;
    logic [7:0]    d;
    assign wr_en = !cpu.PIN_CCS && !cpu.PIN_RW;
    assign rd_en = !cpu.PIN_CCS &&  cpu.PIN_RW;
    assign ab    = cpu.PIN_AB;
    assign d     = cpu.PIN_DB_IN;

    // Next-position and window logic
    logic            pce_i, h_wrap, v_wrap;
    h_t              hcnt_n;
    v_t              vcnt_n;
    logic            field_n;
    logic            hblank, hsync, vblank, vsync_eval, vs_point;
    logic [NIRQ-1:0] irq_set, irq_ack;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        pce_i      = en && (div_cnt == div);
        h_wrap     = (hcnt == htot) || (hcnt == H_MAX);
        v_wrap     = (vcnt == vtot) || (vcnt == V_MAX);
        hcnt_n     = hcnt;
        vcnt_n     = vcnt;
        field_n    = field;
        irq_set    = '0;
        irq_ack    = '0;

        if (pce_i) begin
            hcnt_n = h_wrap ? '0 : hcnt + h_t'(1);
            if (h_wrap) begin
                vcnt_n = v_wrap ? '0 : vcnt + v_t'(1);
                if (v_wrap) field_n = ilace ? ~field : 1'b0;
            end
        end

        hblank     = win(16'(hcnt), 16'(hbs), 16'(hbe));
        hsync      = win(16'(hcnt), 16'(hss), 16'(hse));
        vblank     = win(16'(vcnt), 16'(vbs), 16'(vbe));
        // V sync is sampled once per line: at H=0, or mid-line in the odd
        // interlaced field so that field's sync starts half a line later.
        vsync_eval = win(16'(vcnt_n), 16'(vss), 16'(vse));
        vs_point   = pce_i && ((ilace && field_n) ? (hcnt_n == (htot >> 1)) : (hcnt_n == '0));

        for (int k = 0; k < NIRQ; k++) begin
            irq_set[k] = pce_i && irq_mask[k] && (hcnt_n == '0) && (vcnt_n == line_r[k]);
        end
        if (wr_en && (ab == 5'h16)) irq_ack = d[NIRQ-1:0];
    end

    // Register file, shadows and IRQ status
    always_ff @(posedge PIN_CLK) begin
        if (PIN_RESET) begin
            // NOTE: sequential state is assigned with <= only, so every register
            // samples the pre-edge values regardless of statement order.
            htot <= '0; hbs <= '0; hbe <= '0; hss <= '0; hse <= '0;
            vtot <= '0; vbs <= '0; vbe <= '0; vss <= '0; vse <= '0;
            en <= 1'b0; ilace <= 1'b0; div <= 2'd0;
            irq_mask <= '0; irq_stat <= '0;
            sh_v <= '0; sh_h <= '0;
            // NOTE: the LINE registers are a small array but must come out of
            // reset at 0 like every other register, so they are cleared here.
            for (int k = 0; k < NIRQ; k++) line_r[k] <= '0;
        end else begin
            if (wr_en) begin
                case (ab)
                    5'h00: htot <= put_h(htot, 1'b0, d);
                    5'h01: htot <= put_h(htot, 1'b1, d);
                    5'h02: hbs  <= put_h(hbs,  1'b0, d);
                    5'h03: hbs  <= put_h(hbs,  1'b1, d);
                    5'h04: hbe  <= put_h(hbe,  1'b0, d);
                    5'h05: hbe  <= put_h(hbe,  1'b1, d);
                    5'h06: hss  <= put_h(hss,  1'b0, d);
                    5'h07: hss  <= put_h(hss,  1'b1, d);
                    5'h08: hse  <= put_h(hse,  1'b0, d);
                    5'h09: hse  <= put_h(hse,  1'b1, d);
                    5'h0A: vtot <= put_v(vtot, 1'b0, d);
                    5'h0B: vtot <= put_v(vtot, 1'b1, d);
                    5'h0C: vbs  <= put_v(vbs,  1'b0, d);
                    5'h0D: vbs  <= put_v(vbs,  1'b1, d);
                    5'h0E: vbe  <= put_v(vbe,  1'b0, d);
                    5'h0F: vbe  <= put_v(vbe,  1'b1, d);
                    5'h10: vss  <= put_v(vss,  1'b0, d);
                    5'h11: vss  <= put_v(vss,  1'b1, d);
                    5'h12: vse  <= put_v(vse,  1'b0, d);
                    5'h13: vse  <= put_v(vse,  1'b1, d);
                    5'h14: begin
                        en    <= d[0];
                        ilace <= d[1];
                        div   <= d[3:2];
                    end
                    5'h15: irq_mask <= d[NIRQ-1:0];
                    default: ;
                endcase
                for (int k = 0; k < NIRQ; k++) begin
                    if (ab == 5'(24 + 2 * k)) line_r[k] <= put_v(line_r[k], 1'b0, d);
                    if (ab == 5'(25 + 2 * k)) line_r[k] <= put_v(line_r[k], 1'b1, d);
                end
            end

            // A new raster hit outranks an ack landing on the same clock.
            irq_stat <= (irq_stat & ~irq_ack) | irq_set;

            // Reading VCNT lo freezes both counters for the following byte reads.
            if (rd_en && (ab == 5'h00)) begin
                sh_v <= vcnt;
                sh_h <= hcnt;
            end
        end
    end

    // Divider, counters and field
    always_ff @(posedge PIN_CLK) begin
        if (PIN_RESET || !en) begin
            div_cnt  <= 2'd0;
            hcnt     <= '0;
            vcnt     <= '0;
            field    <= 1'b0;
            vsync_st <= 1'b0;
        end else begin
            div_cnt <= pce_i ? 2'd0 : div_cnt + 2'd1;
            hcnt    <= hcnt_n;
            vcnt    <= vcnt_n;
            field   <= field_n;
            if (vs_point) vsync_st <= vsync_eval;
        end
    end

    // Registered output pins
    always_ff @(posedge PIN_CLK) begin
        if (PIN_RESET) begin
            PIN_PCE  <= 1'b0;
            PIN_NHSY <= 1'b1;
            PIN_NVSY <= 1'b1;
            PIN_NHBK <= 1'b1;
            PIN_NVBK <= 1'b1;
            PIN_NCBK <= 1'b1;
            PIN_NCSY <= 1'b1;
            PIN_INT  <= '1;
        end else begin
            PIN_PCE  <= pce_i;
            PIN_NHSY <= ~(en & hsync);
            PIN_NVSY <= ~(en & vsync_st);
            PIN_NHBK <= ~(en & hblank);
            PIN_NVBK <= ~(en & vblank);
            PIN_NCBK <= ~(en & (hblank | vblank));
            PIN_NCSY <= ~(en & (hsync | vsync_st));
            PIN_INT  <= ~(irq_stat & irq_mask);
        end
    end

    assign PIN_HCNT  = hcnt;
    assign PIN_VCNT  = vcnt;
    assign PIN_FIELD = field;

    // Read mux
    logic [7:0] rd_data;
    always_comb begin
        rd_data = 8'h00;
        if (rd_en) begin
            case (ab)
                5'h00:   rd_data = byte_of(16'(vcnt), 1'b0);
                5'h01:   rd_data = byte_of(16'(sh_v), 1'b1);
                5'h02:   rd_data = byte_of(16'(sh_h), 1'b0);
                5'h03:   rd_data = byte_of(16'(sh_h), 1'b1);
                5'h04:   rd_data = 8'(irq_stat);
                5'h05:   rd_data = {5'b0, field, en & vblank, en & hblank};
                default: rd_data = 8'h00;
            endcase
        end
    end
    assign cpu.PIN_DB_OUT = rd_data;

endmodule
